abus_gnt_responder: RTL and testbench
=====================================

ABUS_GNT_RESPONDER -- requirements
Module: abus_gnt_responder

Interface
REQ-001 The block SHALL provide parameter GNT_DLY, default 2, cycles from sampled req to gnt assertion; legal range 1..3.
REQ-002 The block SHALL provide parameter DEPTH, default 4, capture-FIFO entry count; power of two, at least 2.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req  input  1  request from initiator; level-held until granted.
REQ-006 gnt  output  1  grant; single-cycle pulse.
REQ-007 b  input  1  initiator data bit, captured on the grant cycle.
REQ-008 c  input  1  initiator data bit, captured on the grant cycle.
REQ-009 pop  input  1  consumer removes the FIFO head entry.
REQ-010 a  output  1  FIFO non-empty indication to the initiator.
REQ-011 d_out  output  2  FIFO head entry {b,c}; 2'b00 when empty.
REQ-012 d_oe  output  1  d_out valid; equals a.
REQ-013 ovf  output  1  sticky flag, set when a grant is withheld because the FIFO is full.
REQ-014 gnt_cnt  output  8  saturating count of grants issued.

Function
REQ-015 The FSM SHALL have four states: IDLE, WAIT, GRANT, HOLD.
REQ-016 IDLE->WAIT SHALL occur when req=1 is sampled; the delay counter loads GNT_DLY-1.
REQ-017 In WAIT, while the counter is nonzero, the counter SHALL decrement each cycle.
REQ-018 In WAIT, at counter=0 with the FIFO not full, the FSM SHALL go to GRANT.
REQ-019 In WAIT, at counter=0 with the FIFO full, the FSM SHALL stay in WAIT, keep the counter at 0 and set ovf.
REQ-020 gnt SHALL be 1 exactly in GRANT, registered, so gnt rises GNT_DLY cycles after the req-sampling edge; with FIFO space this meets req ##[1:3] gnt.
REQ-021 In GRANT, {b,c} SHALL be pushed into the FIFO and gnt_cnt SHALL increment, saturating at 255; the FSM then goes to HOLD.
REQ-022 The FSM SHALL stay in HOLD while req=1 and go to IDLE on req=0; one req level yields exactly one grant.
REQ-023 In WAIT, req=0 SHALL abort to IDLE with no grant and no push.
REQ-024 pop SHALL remove the head entry when non-empty; pop when empty SHALL be ignored with no pointer change.
REQ-025 Push and pop in the same cycle SHALL both occur, including when full, and occupancy SHALL be unchanged.
REQ-026 FIFO pointers SHALL wrap modulo DEPTH, with a separate occupancy count of width log2(DEPTH)+1.
REQ-027 a, d_oe and d_out SHALL be combinational from FIFO state, so the first entry is visible the cycle after the push edge.
REQ-028 ovf SHALL clear only on reset.

Reset
REQ-029 Assertion of rst_n=0 SHALL immediately force FSM=IDLE, counter=0, FIFO empty with pointers 0, gnt=0, a=0, d_oe=0, d_out=2'b00, ovf=0, gnt_cnt=0.
REQ-030 Reset mid-transaction SHALL discard the pending grant; after deassertion, a held req SHALL be treated as a new request.
REQ-031 Reset deassertion SHALL be used synchronously, taking effect on the first clk edge after release.

Verification
REQ-032 GNT_DLY=2, req rises at edge 0 and is held: gnt=1 only in the cycle after edge 2; gnt_cnt=1; a=1; d_out equals {b,c} sampled at the grant edge.
REQ-033 For each GNT_DLY in {1,2,3}: gnt lands at offset 1, 2 or 3 respectively; an assertion-checker for req ##[1:3] gnt passes.
REQ-034 Issue 4 grants with pop=0 (DEPTH=4), then a 5th req: no gnt, ovf=1, FSM in WAIT; then pop=1 for one cycle: gnt is issued the next cycle and the entries are read in order.
REQ-035 Drop req in WAIT (GNT_DLY=3, req held 2 cycles): no gnt, FIFO unchanged, FSM returns to IDLE.
REQ-036 Assert rst_n=0 with FSM in WAIT and 2 entries in the FIFO: all outputs reach reset values without a clk edge; after release with req held, gnt is issued GNT_DLY cycles later.
REQ-037 Push and pop together when full, and pop when empty: occupancy and ovf are unchanged; 300 grants leave gnt_cnt=255.

Source files
------------

// File: rtl/abus_gnt_responder.sv
// Grant responder for the A-bus. A request is granted with a fixed delay, and
// {b,c} is captured on the grant cycle into a small FIFO that a consumer drains.
module abus_gnt_responder #(
    parameter int GNT_DLY = 2,
    parameter int DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    output logic       gnt,
    input  logic       b,
    input  logic       c,
    input  logic       pop,
    output logic       a,
    output logic [1:0] d_out,
    output logic       d_oe,
    output logic       ovf,
    output logic [7:0] gnt_cnt
);

    localparam int          AW   = $clog2(DEPTH);
    localparam int          CW   = AW + 1;
    localparam logic [1:0]  LOAD = 2'(GNT_DLY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GRANT, S_HOLD} state_t;

    state_t          r_state;
    logic [1:0]      r_cnt;
    logic            r_gnt;
    logic            r_ovf;
    logic [7:0]      r_gnt_cnt;

    logic [1:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    // The FSM never enters GRANT while full, so the full guard only matters with a pop.
    assign w_push  = (r_state == S_GRANT) && (!w_full || w_pop);
    assign w_pop   = pop && !w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_gnt     <= 1'b0;
            r_ovf     <= 1'b0;
            r_gnt_cnt <= '0;
        end else begin
            r_gnt <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_state <= S_WAIT;
                        r_cnt   <= LOAD;
                    end
                end
                S_WAIT: begin
                    if (!req) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt != 2'd0) begin
                        r_cnt <= r_cnt - 2'd1;
                    end else if (w_full) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_state <= S_GRANT;
                        r_gnt   <= 1'b1;
                    end
                end
                S_GRANT: begin
                    r_state <= S_HOLD;
                    if (r_gnt_cnt != 8'hFF) r_gnt_cnt <= r_gnt_cnt + 8'd1;
                end
                S_HOLD: begin
                    if (!req) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 2'b00;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= {b, c};
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign ovf     = r_ovf;
    assign gnt_cnt = r_gnt_cnt;
    assign a       = !w_empty;
    assign d_oe    = !w_empty;
    assign d_out   = w_empty ? 2'b00 : r_mem[r_rptr];

endmodule

// File: tb/tb_abus_gnt_responder.sv
// Bench for abus_gnt_responder: three instances (GNT_DLY 1..3) share stimulus
// and are compared each cycle against a transaction-level model.
module tb_abus_gnt_responder;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n, req, b, c, pop;
    logic [2:0]      gnt_v, a_v, oe_v, ovf_v;
    logic [2:0][1:0] dout_v;
    logic [2:0][7:0] cnt_v;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        abus_gnt_responder #(.GNT_DLY(k + 1), .DEPTH(DEPTH)) u_dut (
            .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt_v[k]),
            .b(b), .c(c), .pop(pop), .a(a_v[k]), .d_out(dout_v[k]),
            .d_oe(oe_v[k]), .ovf(ovf_v[k]), .gnt_cnt(cnt_v[k])
        );
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: a request is "accepted" on an edge with req=1 while idle, and is
    // granted on the first edge at least GNT_DLY later when the queue has room.
    bit         m_busy [3];
    bit         m_hold [3];
    bit         m_gnt  [3];
    bit         m_ovf  [3];
    int         m_since[3];
    int         m_gc   [3];
    int         m_head [3];
    int         m_cnt  [3];
    logic [1:0] m_buf  [3][DEPTH];
    int         edge_n = 0;

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            m_busy[k] = 0; m_hold[k] = 0; m_gnt[k] = 0; m_ovf[k] = 0;
            m_since[k] = 0; m_gc[k] = 0; m_head[k] = 0; m_cnt[k] = 0;
        end
    endfunction

    function automatic void model_edge();
        for (int k = 0; k < 3; k++) begin
            bit full, push, popv;
            full = (m_cnt[k] == DEPTH);
            push = m_gnt[k];
            popv = pop && (m_cnt[k] > 0);
            if (m_gnt[k]) begin
                m_gnt[k]  = 0;
                m_hold[k] = 1;
            end else if (m_hold[k]) begin
                if (!req) m_hold[k] = 0;
            end else if (m_busy[k]) begin
                if (!req) m_busy[k] = 0;
                else if (edge_n >= m_since[k] + k + 1) begin
                    if (full) m_ovf[k] = 1;
                    else begin
                        m_gnt[k]  = 1;
                        m_busy[k] = 0;
                    end
                end
            end else if (req) begin
                m_busy[k]  = 1;
                m_since[k] = edge_n;
            end
            if (popv) begin
                m_head[k] = (m_head[k] + 1) % DEPTH;
                m_cnt[k]--;
            end
            if (push) begin
                m_buf[k][(m_head[k] + m_cnt[k]) % DEPTH] = {b, c};
                m_cnt[k]++;
                if (m_gc[k] < 255) m_gc[k]++;
            end
        end
        edge_n++;
    endfunction

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            int ed;
            ed = (m_cnt[k] > 0) ? int'(m_buf[k][m_head[k]]) : 0;
            chk($sformatf("gnt[%0d]", k),     int'(gnt_v[k]),  int'(m_gnt[k]));
            chk($sformatf("a[%0d]", k),       int'(a_v[k]),    int'(m_cnt[k] > 0));
            chk($sformatf("d_oe[%0d]", k),    int'(oe_v[k]),   int'(m_cnt[k] > 0));
            chk($sformatf("d_out[%0d]", k),   int'(dout_v[k]), ed);
            chk($sformatf("ovf[%0d]", k),     int'(ovf_v[k]),  int'(m_ovf[k]));
            chk($sformatf("gnt_cnt[%0d]", k), int'(cnt_v[k]),  m_gc[k]);
        end
    endtask

    // Inputs change at negedge; model advances on posedge; outputs checked at next negedge.
    task automatic step(input bit r, input bit bb, input bit cc, input bit p);
        req = r; b = bb; c = cc; pop = p;
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic async_reset(input bit r);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        step(r, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic one_req(input bit bb, input bit cc, input bit p);
        for (int i = 0; i < 5; i++) step(1'b1, bb, cc, p);
        step(1'b0, 1'b0, 1'b0, p);
    endtask

    initial begin
        bit r;
        rst_n = 1'b1; req = 1'b0; b = 1'b0; c = 1'b0; pop = 1'b0;
        @(negedge clk);
        async_reset(1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // basic grant with data capture
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // fill to DEPTH, then a stalled request that sets ovf
        one_req(1'b0, 1'b1, 1'b0);
        one_req(1'b1, 1'b0, 1'b0);
        one_req(1'b1, 1'b1, 1'b0);
        one_req(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b1);

        // abort while waiting
        one_req(1'b1, 1'b0, 1'b0);
        one_req(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // reset mid-request with entries queued, req held across release
        step(1'b1, 1'b1, 1'b0, 1'b0);
        async_reset(1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // random traffic
        r = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) r = ~r;
            step(r, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // saturate gnt_cnt, draining continuously
        for (int n = 0; n < 300; n++) one_req(1'($urandom), 1'($urandom), 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
